// File: rtl/adc_readout_sequencer_pkg.sv
// Shared constants and helpers for the CFEB readout timing sequencer.
// Default geometry matches the CFEB top level (six ADCs, slot 1 preset on SYNC).
package adc_readout_sequencer_pkg;

    localparam int NCH_DEFAULT         = 6;
    localparam int PRESET_SLOT_DEFAULT = 1;
    localparam int NCH_MAX             = 16;
    localparam int SLOT_W_MAX          = 4;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic logic [NCH_MAX-1:0] onehot_dec(input logic [SLOT_W_MAX-1:0] idx);
        logic [NCH_MAX-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tmr_reg.sv
// State register with optional triple redundancy; the voted value is both the
// output and the only value the surrounding next-state logic ever sees.
module tmr_reg #(
    parameter int               WIDTH   = 1,
    parameter bit               TMR     = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             ld_edg_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (TMR) begin : g_tmr
        logic [WIDTH-1:0] copy_a_q, copy_b_q, copy_c_q;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge CLK or posedge ld_edg_rst) begin
            if (ld_edg_rst) begin
                copy_a_q <= RST_VAL;
                copy_b_q <= RST_VAL;
                copy_c_q <= RST_VAL;
            end else begin
                copy_a_q <= d;
                copy_b_q <= d;
                copy_c_q <= d;
            end
        end

        // Bitwise majority: a single upset copy is outvoted and rewritten next edge.
        assign q = (copy_a_q & copy_b_q) | (copy_a_q & copy_c_q) | (copy_b_q & copy_c_q);
    end else begin : g_plain
        logic [WIDTH-1:0] reg_q;

        always_ff @(posedge CLK or posedge ld_edg_rst) begin
            if (ld_edg_rst) begin
                reg_q <= RST_VAL;
            end else begin
                reg_q <= d;
            end
        end

        assign q = reg_q;
    end

endmodule

// File: rtl/adc_readout_sequencer.sv
// CFEB readout timing sequencer: rotating ADC output-enable ring, phase-locked
// ADCCLK, LPUSH_B frame strobe, delayed END toggle and sticky load overrun.
module adc_readout_sequencer
    import adc_readout_sequencer_pkg::*;
#(
    parameter int NCH          = NCH_DEFAULT,
    parameter int PRESET_SLOT  = PRESET_SLOT_DEFAULT,
    parameter int ADC_HI_START = 3,
    parameter int END_DLY      = 5,
    parameter bit TMR          = 1'b0
) (
    input  logic                  CLK,
    input  logic                  ld_edg_rst,
    input  logic                  SYNC,
    input  logic [NCH-1:0]        CH_MASK,
    input  logic                  XLOAD,
    input  logic                  PUSH,
    input  logic                  SENDCHECK,
    input  logic                  LASTWORD,
    output logic [NCH-1:0]        OEN_B,
    output logic                  ADCCLK,
    output logic                  LPUSH_B,
    output logic                  END,
    output logic [clog2(NCH)-1:0] SLOT,
    output logic                  OVERRUN
);

    localparam int            SW        = clog2(NCH);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);
    localparam logic [SW-1:0] PRESET    = SW'(PRESET_SLOT);

    logic [SW-1:0]      slot_q, slot_d;
    logic               armed_q, armed_d;
    logic               push_lat_q, push_lat_d;
    logic               load_pend_q, load_pend_d;
    logic               lw_q, lw_d;

    logic [NCH-1:0]     oen_b_q, oen_b_d;
    logic               adcclk_q, adcclk_d;
    logic               lpush_b_q, lpush_b_d;
    logic               overrun_q, overrun_d;
    logic [END_DLY-1:0] end_dly_q, end_dly_d;

    logic               fb;
    logic               win;

    tmr_reg #(.WIDTH(SW), .TMR(TMR), .RST_VAL(PRESET)) u_slot (
        .CLK(CLK), .ld_edg_rst(ld_edg_rst), .d(slot_d), .q(slot_q)
    );
    tmr_reg #(.WIDTH(1), .TMR(TMR), .RST_VAL(1'b0)) u_armed (
        .CLK(CLK), .ld_edg_rst(ld_edg_rst), .d(armed_d), .q(armed_q)
    );
    tmr_reg #(.WIDTH(1), .TMR(TMR), .RST_VAL(1'b0)) u_push_lat (
        .CLK(CLK), .ld_edg_rst(ld_edg_rst), .d(push_lat_d), .q(push_lat_q)
    );
    tmr_reg #(.WIDTH(1), .TMR(TMR), .RST_VAL(1'b0)) u_load_pend (
        .CLK(CLK), .ld_edg_rst(ld_edg_rst), .d(load_pend_d), .q(load_pend_q)
    );
    tmr_reg #(.WIDTH(1), .TMR(TMR), .RST_VAL(1'b0)) u_lw (
        .CLK(CLK), .ld_edg_rst(ld_edg_rst), .d(lw_d), .q(lw_q)
    );

    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    always_comb begin
        fb = (slot_q == LAST_SLOT) && !SYNC;

        if (SYNC) begin
            slot_d = PRESET;
        end else if (slot_q == LAST_SLOT) begin
            slot_d = '0;
        end else begin
            slot_d = slot_q + SW'(1);
        end

        armed_d     = fb ? (load_pend_q | XLOAD) : armed_q;
        push_lat_d  = fb ? PUSH : push_lat_q;
        load_pend_d = fb ? 1'b0 : (load_pend_q | XLOAD);
        overrun_d   = overrun_q | (XLOAD & load_pend_q & !fb);

        lw_d = lw_q ^ (LASTWORD & CH_MASK[slot_q]);

        // Outputs are registered from the next slot so they line up with SLOT.
        oen_b_d  = ~(NCH'(onehot_dec(SLOT_W_MAX'(slot_d))) & CH_MASK);
        adcclk_d = ((int'(slot_d) + NCH - ADC_HI_START) % NCH) < (NCH / 2);

        win       = !SENDCHECK || (slot_q == '0) || (slot_q == LAST_SLOT);
        lpush_b_d = !(armed_q & push_lat_q & win);

        end_dly_d = END_DLY'({end_dly_q, lw_q});
    end

    always_ff @(posedge CLK or posedge ld_edg_rst) begin
        if (ld_edg_rst) begin
            oen_b_q   <= '1;
            adcclk_q  <= 1'b0;
            lpush_b_q <= 1'b1;
            overrun_q <= 1'b0;
            end_dly_q <= '0;
        end else begin
            oen_b_q   <= oen_b_d;
            adcclk_q  <= adcclk_d;
            lpush_b_q <= lpush_b_d;
            overrun_q <= overrun_d;
            end_dly_q <= end_dly_d;
        end
    end

    assign OEN_B   = oen_b_q;
    assign ADCCLK  = adcclk_q;
    assign LPUSH_B = lpush_b_q;
    assign END     = end_dly_q[END_DLY-1];
    assign SLOT    = slot_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_adc_readout_sequencer.sv
// Directed bench: plain and triplicated sequencers run side by side on the same
// stimulus and are checked against hand-derived slot/strobe expectations.
module tb_adc_readout_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync, xload, push, sendcheck, lastword;
    logic [5:0] ch_mask;

    logic [5:0] oen_b0, oen_b1;
    logic       adcclk0, adcclk1, lpush_b0, lpush_b1, end0, end1, overrun0, overrun1;
    logic [2:0] slot0, slot1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_slot;
    logic [5:0] edge_mask;
    logic [5:0] adc_hi_tbl = 6'b111000;
    logic [6:0] lp_sc_tbl  = 7'b1011110;
    logic [2:0] bad;

    always #5 clk = ~clk;

    adc_readout_sequencer #(.TMR(1'b0)) dut0 (
        .CLK(clk), .ld_edg_rst(rst), .SYNC(sync), .CH_MASK(ch_mask), .XLOAD(xload),
        .PUSH(push), .SENDCHECK(sendcheck), .LASTWORD(lastword), .OEN_B(oen_b0),
        .ADCCLK(adcclk0), .LPUSH_B(lpush_b0), .END(end0), .SLOT(slot0), .OVERRUN(overrun0)
    );

    adc_readout_sequencer #(.TMR(1'b1)) dut1 (
        .CLK(clk), .ld_edg_rst(rst), .SYNC(sync), .CH_MASK(ch_mask), .XLOAD(xload),
        .PUSH(push), .SENDCHECK(sendcheck), .LASTWORD(lastword), .OEN_B(oen_b1),
        .ADCCLK(adcclk1), .LPUSH_B(lpush_b1), .END(end1), .SLOT(slot1), .OVERRUN(overrun1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [31:0] got0, input logic [31:0] got1,
                          input logic [31:0] exp);
        check({tag, "_tmr0"}, got0, exp);
        check({tag, "_tmr1"}, got1, exp);
    endtask

    task automatic check_ring();
        logic [5:0] exp_oen;
        exp_oen = ~((6'b000001 << exp_slot) & edge_mask);
        check2("slot", 32'(slot0), 32'(slot1), 32'(exp_slot));
        check2("oen_b", 32'(oen_b0), 32'(oen_b1), 32'(exp_oen));
        check2("adcclk", 32'(adcclk0), 32'(adcclk1), 32'(adc_hi_tbl[exp_slot]));
    endtask

    task automatic step();
        logic [2:0] nxt;
        if (sync) nxt = 3'd1;
        else if (exp_slot == 3'd5) nxt = 3'd0;
        else nxt = exp_slot + 3'd1;
        edge_mask = ch_mask;
        @(posedge clk);
        #1;
        exp_slot = nxt;
        check_ring();
    endtask

    task automatic goto_slot(input logic [2:0] target);
        for (int i = 0; i < 6 && exp_slot != target; i++) step();
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; xload = 1'b0; push = 1'b0; sendcheck = 1'b0; lastword = 1'b0;
        ch_mask = 6'h3F; exp_slot = 3'd1; edge_mask = 6'h3F;
        #2;
        check2("rst_slot", 32'(slot0), 32'(slot1), 32'd1);
        check2("rst_oen_b", 32'(oen_b0), 32'(oen_b1), 32'h3F);
        check2("rst_adcclk", 32'(adcclk0), 32'(adcclk1), 32'd0);
        check2("rst_lpush_b", 32'(lpush_b0), 32'(lpush_b1), 32'd1);
        check2("rst_end", 32'(end0), 32'(end1), 32'd0);
        check2("rst_overrun", 32'(overrun0), 32'(overrun1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free-running ring, two full frames.
        repeat (12) step();

        // SYNC at slot 4 restarts the frame at the preset slot.
        goto_slot(3'd4);
        sync = 1'b1;
        step();
        sync = 1'b0;
        repeat (3) step();

        // Masked channels 1 and 4.
        ch_mask = 6'b101101;
        for (int k = 0; k < 6; k++) begin
            step();
            if (exp_slot == 3'd1 || exp_slot == 3'd4)
                check2("oen_masked", 32'(oen_b0), 32'(oen_b1), 32'h3F);
        end
        goto_slot(3'd1);
        lastword = 1'b1;
        step();
        lastword = 1'b0;
        repeat (7) begin
            step();
            check2("end_ignored", 32'(end0), 32'(end1), 32'd0);
        end
        goto_slot(3'd2);
        lastword = 1'b1;
        step();
        lastword = 1'b0;
        check2("end_e0", 32'(end0), 32'(end1), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check2("end_dly", 32'(end0), 32'(end1), 32'(k == 5));
        end
        ch_mask = 6'h3F;

        // Load + push, whole frame window.
        goto_slot(3'd2);
        xload = 1'b1;
        step();
        xload = 1'b0;
        push  = 1'b1;
        check2("ovr_single", 32'(overrun0), 32'(overrun1), 32'd0);
        goto_slot(3'd5);
        step();
        check2("lpush_pre", 32'(lpush_b0), 32'(lpush_b1), 32'd1);
        for (int k = 0; k < 7; k++) begin
            step();
            check2("lpush_full", 32'(lpush_b0), 32'(lpush_b1), 32'(k == 6));
        end

        // Same with check-word gating: only first/last slot strobes.
        sendcheck = 1'b1;
        goto_slot(3'd2);
        xload = 1'b1;
        step();
        xload = 1'b0;
        goto_slot(3'd5);
        step();
        check2("lpush_sc_pre", 32'(lpush_b0), 32'(lpush_b1), 32'd1);
        for (int k = 0; k < 7; k++) begin
            step();
            check2("lpush_sc", 32'(lpush_b0), 32'(lpush_b1), 32'(lp_sc_tbl[k]));
        end
        sendcheck = 1'b0;
        push      = 1'b0;

        // Overrun boundaries: pending load plus XLOAD at the boundary is consumed.
        goto_slot(3'd2);
        xload = 1'b1;
        step();
        xload = 1'b0;
        goto_slot(3'd5);
        xload = 1'b1;
        step();
        xload = 1'b0;
        check2("ovr_at_fb", 32'(overrun0), 32'(overrun1), 32'd0);
        goto_slot(3'd5);
        xload = 1'b1;
        step();
        xload = 1'b0;
        check2("ovr_fb_alone", 32'(overrun0), 32'(overrun1), 32'd0);
        goto_slot(3'd1);
        xload = 1'b1;
        step();
        xload = 1'b0;
        check2("ovr_first", 32'(overrun0), 32'(overrun1), 32'd0);
        goto_slot(3'd3);
        xload = 1'b1;
        step();
        xload = 1'b0;
        check2("ovr_set", 32'(overrun0), 32'(overrun1), 32'd1);
        repeat (8) step();
        check2("ovr_sticky", 32'(overrun0), 32'(overrun1), 32'd1);

        // Upset one slot copy in the triplicated instance.
        bad = 3'((int'(exp_slot) + 3) % 6);
        force dut1.u_slot.g_tmr.copy_b_q = bad;
        #2;
        check("tmr_forced", 32'(dut1.u_slot.g_tmr.copy_b_q), 32'(bad));
        check_ring();
        release dut1.u_slot.g_tmr.copy_b_q;
        step();
        check("tmr_realign", 32'(dut1.u_slot.g_tmr.copy_b_q), 32'(exp_slot));

        // Asynchronous reset while LPUSH_B is low.
        push = 1'b1;
        goto_slot(3'd2);
        xload = 1'b1;
        step();
        xload = 1'b0;
        goto_slot(3'd5);
        repeat (3) step();
        check2("lpush_before_rst", 32'(lpush_b0), 32'(lpush_b1), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check2("arst_lpush_b", 32'(lpush_b0), 32'(lpush_b1), 32'd1);
        check2("arst_oen_b", 32'(oen_b0), 32'(oen_b1), 32'h3F);
        check2("arst_slot", 32'(slot0), 32'(slot1), 32'd1);
        check2("arst_adcclk", 32'(adcclk0), 32'(adcclk1), 32'd0);
        check2("arst_end", 32'(end0), 32'(end1), 32'd0);
        check2("arst_overrun", 32'(overrun0), 32'(overrun1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
